// File: rtl/ws2812b_frame_ctrl.sv
// Frame sequencer for the WS2812B bit driver: fetches NUM_LEDS GRB words,
// streams each MSB-first as write0/write1 requests, then issues one latch request.
module ws2812b_frame_ctrl #(
  parameter int NUM_LEDS    = 8,
  parameter int ADDR_W      = 3,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              clk_50Mhz,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              drv_write0,
  output logic              drv_write1,
  output logic              drv_latch,
  input  logic              drv_ready
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_LOAD     = 4'd2;
  localparam logic [3:0] S_SEND     = 4'd3;
  localparam logic [3:0] S_WAIT_LO  = 4'd4;
  localparam logic [3:0] S_WAIT_HI  = 4'd5;
  localparam logic [3:0] S_LATCH    = 4'd6;
  localparam logic [3:0] S_LWAIT_LO = 4'd7;
  localparam logic [3:0] S_LWAIT_HI = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  logic [3:0]        state;
  logic [23:0]       shreg;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] pix_idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_next;

  assign tmo_next = tmo_cnt + TMO_ONE;

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pix_rd     <= 1'b0;
      pix_addr   <= '0;
      drv_write0 <= 1'b0;
      drv_write1 <= 1'b0;
      drv_latch  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      pix_idx    <= '0;
      tmo_cnt    <= '0;
    end else begin
      pix_rd     <= 1'b0;
      drv_write0 <= 1'b0;
      drv_write1 <= 1'b0;
      drv_latch  <= 1'b0;
      done       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            err     <= 1'b0;
            busy    <= 1'b1;
            pix_idx <= '0;
            state   <= S_FETCH;
          end
        end

        S_FETCH: begin
          pix_rd   <= 1'b1;
          pix_addr <= pix_idx;
          state    <= S_LOAD;
        end

        S_LOAD: begin
          shreg   <= pix_data;
          bit_cnt <= 5'd23;
          state   <= S_SEND;
        end

        S_SEND: begin
          drv_write1 <= shreg[23];
          drv_write0 <= ~shreg[23];
          tmo_cnt    <= '0;
          state      <= S_WAIT_LO;
        end

        // A driver that never drops ready aborts the frame without a done pulse.
        S_WAIT_LO, S_LWAIT_LO: begin
          if (!drv_ready) begin
            state <= (state == S_WAIT_LO) ? S_WAIT_HI : S_LWAIT_HI;
          end else if (tmo_next == TMO_LIMIT) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        S_WAIT_HI: begin
          if (drv_ready) begin
            if (bit_cnt != 5'd0) begin
              shreg   <= {shreg[22:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
              state   <= S_SEND;
            end else if (pix_idx != LAST_IDX) begin
              pix_idx <= pix_idx + IDX_ONE;
              state   <= S_FETCH;
            end else begin
              state <= S_LATCH;
            end
          end
        end

        S_LATCH: begin
          drv_latch <= 1'b1;
          tmo_cnt   <= '0;
          state     <= S_LWAIT_LO;
        end

        S_LWAIT_HI: begin
          if (drv_ready) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Directed bench: a 1-pixel and a 2-pixel controller, each driven by a
// behavioural WS2812B driver model (ready drops 2 cycles after a request).
module tb_ws2812b_frame_ctrl;

  localparam int BIT_BUSY   = 62;
  localparam int LATCH_BUSY = 4000;

  logic        clk_50Mhz = 1'b0;
  logic        reset;
  logic [1:0]  start;
  logic [1:0]  busy, done, err, pix_rd, w0, w1, lat;
  logic [1:0]  rdy = 2'b11;
  logic [2:0]  addr0, addr1;
  logic [23:0] pd0, pd1;
  logic [23:0] buf0;
  logic [23:0] buf1 [0:7];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit stuck    = 1'b0;

  int dly [2];
  int bz [2];
  int rise_cyc [2];

  int req0_q[$];
  int done0_cnt = 0;
  int req1_q[$];
  int req1_cyc_q[$];
  int gap1_q[$];
  int addr1_q[$];
  int rd1_cyc_q[$];
  int done1_cnt = 0;
  int lat1_cnt = 0;
  int multi_req = 0;
  int done_busy_bad = 0;

  ws2812b_frame_ctrl #(.NUM_LEDS(1), .ADDR_W(3), .ACK_TIMEOUT(8)) u_dut0 (
    .clk_50Mhz (clk_50Mhz),
    .reset     (reset),
    .start     (start[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .err       (err[0]),
    .pix_rd    (pix_rd[0]),
    .pix_addr  (addr0),
    .pix_data  (pd0),
    .drv_write0(w0[0]),
    .drv_write1(w1[0]),
    .drv_latch (lat[0]),
    .drv_ready (rdy[0])
  );

  ws2812b_frame_ctrl #(.NUM_LEDS(2), .ADDR_W(3), .ACK_TIMEOUT(8)) u_dut1 (
    .clk_50Mhz (clk_50Mhz),
    .reset     (reset),
    .start     (start[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .err       (err[1]),
    .pix_rd    (pix_rd[1]),
    .pix_addr  (addr1),
    .pix_data  (pd1),
    .drv_write0(w0[1]),
    .drv_write1(w1[1]),
    .drv_latch (lat[1]),
    .drv_ready (rdy[1])
  );

  always #10 clk_50Mhz = ~clk_50Mhz;
  always @(posedge clk_50Mhz) cyc <= cyc + 1;

  assign pd0 = buf0;
  assign pd1 = buf1[addr1];

  // Driver model and request logger, sampled on the falling edge.
  always @(negedge clk_50Mhz) begin
    for (int i = 0; i < 2; i++) begin
      if (dly[i] > 0) begin
        dly[i] = dly[i] - 1;
        if (dly[i] == 0) rdy[i] = 1'b0;
      end else if (!rdy[i]) begin
        bz[i] = bz[i] - 1;
        if (bz[i] == 0) begin
          rdy[i] = 1'b1;
          rise_cyc[i] = cyc;
        end
      end
      if ((w0[i] | w1[i] | lat[i]) && !(i == 1 && stuck)) begin
        dly[i] = 2;
        bz[i]  = lat[i] ? LATCH_BUSY : BIT_BUSY;
      end
      if (int'(w0[i]) + int'(w1[i]) + int'(lat[i]) > 1) multi_req++;
      if (done[i] && busy[i]) done_busy_bad++;
    end
    if (w0[0]) req0_q.push_back(0);
    if (w1[0]) req0_q.push_back(1);
    if (lat[0]) req0_q.push_back(2);
    if (done[0]) done0_cnt++;
    if (w0[1] | w1[1] | lat[1]) begin
      req1_q.push_back(lat[1] ? 2 : (w1[1] ? 1 : 0));
      req1_cyc_q.push_back(cyc);
      gap1_q.push_back(cyc - rise_cyc[1]);
    end
    if (lat[1]) lat1_cnt++;
    if (pix_rd[1]) begin
      addr1_q.push_back(int'(addr1));
      rd1_cyc_q.push_back(cyc);
    end
    if (done[1]) done1_cnt++;
  end

  function automatic int exp_req(input logic [23:0] p0, input logic [23:0] p1, input int pos);
    logic [23:0] w;
    if (pos >= 48) return 2;
    w = (pos < 24) ? p0 : p1;
    return int'(w[23 - (pos % 24)]);
  endfunction

  task automatic tick();
    @(negedge clk_50Mhz);
    #1;
  endtask

  task automatic clear_logs1();
    req1_q.delete();
    req1_cyc_q.delete();
    gap1_q.delete();
    addr1_q.delete();
    rd1_cyc_q.delete();
  endtask

  task automatic pulse_start1(output int sc);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_busy_low(input int idx, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      tick();
      if (!busy[idx]) ok = 1'b1;
    end
  endtask

  task automatic wait_latch_rise(output bit ok);
    int l0;
    int ph;
    l0 = lat1_cnt;
    ph = 0;
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      tick();
      if (ph == 0 && lat1_cnt > l0) ph = 1;
      else if (ph == 1 && !rdy[1]) ph = 2;
      else if (ph == 2 && rdy[1]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 2'b00;
    repeat (3) tick();
    n_checks++;
    if (busy !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b err=%b expected all 0", busy, done, err);
    end
    n_checks++;
    if (pix_rd !== 2'b00 || addr0 !== 3'd0 || addr1 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_pix: pix_rd=%b addr0=%0d addr1=%0d expected 0", pix_rd, addr0, addr1);
    end
    n_checks++;
    if ((w0 | w1 | lat) !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_req: w0=%b w1=%b lat=%b expected 0", w0, w1, lat);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pixel();
    bit ok;
    int mism;
    int e;
    buf0 = 24'hFF0000;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: got %b expected 1", busy[0]);
    end
    wait_busy_low(0, 20000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: busy still %b expected 0", busy[0]);
    end
    n_checks++;
    if (req0_q.size() != 25) begin
      n_fail++;
      $display("FAIL single_count: got %0d requests expected 25", req0_q.size());
    end
    mism = 0;
    foreach (req0_q[i]) begin
      e = (i < 8) ? 1 : ((i < 24) ? 0 : 2);
      if (req0_q[i] != e) mism++;
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL single_stream: %0d wrong requests expected 0", mism);
    end
    n_checks++;
    if (done0_cnt != 1) begin
      n_fail++;
      $display("FAIL single_done: got %0d pulses expected 1", done0_cnt);
    end
    n_checks++;
    if (err[0] !== 1'b0 || done_busy_bad != 0) begin
      n_fail++;
      $display("FAIL single_err_busy: err=%b done_with_busy=%0d expected 0 0", err[0], done_busy_bad);
    end
  endtask

  task automatic test_two_pixels();
    bit ok;
    int sc;
    int d0;
    int mism;
    int e;
    buf1[0] = 24'h000001;
    buf1[1] = 24'h800000;
    clear_logs1();
    d0 = done1_cnt;
    pulse_start1(sc);
    wait_busy_low(1, 20000, ok);
    n_checks++;
    if (!ok || req1_q.size() != 49) begin
      n_fail++;
      $display("FAIL two_count: ok=%0d got %0d requests expected 49", ok, req1_q.size());
    end
    mism = 0;
    foreach (req1_q[i]) begin
      e = (i < 23) ? 0 : ((i < 25) ? 1 : ((i < 48) ? 0 : 2));
      if (req1_q[i] != e) mism++;
    end
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL two_stream: %0d wrong requests expected 0", mism);
    end
    n_checks++;
    if (addr1_q.size() != 2 || addr1_q[0] != 0 || addr1_q[1] != 1) begin
      n_fail++;
      $display("FAIL two_addr: %0d reads first=%0d expected 2 reads 0,1", addr1_q.size(), addr1_q[0]);
    end
    n_checks++;
    if (rd1_cyc_q[0] - sc != 1) begin
      n_fail++;
      $display("FAIL two_rd_latency: got %0d expected 1", rd1_cyc_q[0] - sc);
    end
    n_checks++;
    if (req1_cyc_q[0] - sc != 3) begin
      n_fail++;
      $display("FAIL two_req_latency: got %0d expected 3", req1_cyc_q[0] - sc);
    end
    // Edges from the model raising ready to the next request being visible.
    n_checks++;
    if (gap1_q[1] != 2) begin
      n_fail++;
      $display("FAIL two_bit_gap: got %0d expected 2", gap1_q[1]);
    end
    n_checks++;
    if (gap1_q[24] != 4) begin
      n_fail++;
      $display("FAIL two_pixel_gap: got %0d expected 4", gap1_q[24]);
    end
    n_checks++;
    if (done1_cnt != d0 + 1 || err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL two_done: got %0d pulses err=%b expected 1 err=0", done1_cnt - d0, err[1]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit found;
    int sc;
    int d0;
    buf1[0] = 24'h000001;
    buf1[1] = 24'h000000;
    clear_logs1();
    d0 = done1_cnt;
    stuck = 1'b1;
    pulse_start1(sc);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (w0[1] | w1[1]) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found || w0[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_first_req: found=%0d w0=%b expected 1 1", found, w0[1]);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        n_checks++;
        if (err[1] !== 1'b0 || busy[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_early: cycle 7 err=%b busy=%b expected 0 1", err[1], busy[1]);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (err[1] !== 1'b1 || busy[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_abort: cycle 8 err=%b busy=%b expected 1 0", err[1], busy[1]);
        end
      end
    end
    repeat (30) tick();
    n_checks++;
    if (req1_q.size() != 1 || done1_cnt != d0 || err[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_quiet: %0d requests %0d dones err=%b expected 1 0 1", req1_q.size(), done1_cnt - d0, err[1]);
    end
    stuck = 1'b0;
    pulse_start1(sc);
    n_checks++;
    if (err[1] !== 1'b0 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_clear: err=%b busy=%b expected 0 1", err[1], busy[1]);
    end
    wait_busy_low(1, 20000, ok);
    n_checks++;
    if (!ok || req1_q.size() != 50 || done1_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL tmo_recover: ok=%0d %0d requests %0d dones expected 1 50 1", ok, req1_q.size(), done1_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sc;
    int d0;
    int mism;
    buf1[0] = 24'h123456;
    buf1[1] = 24'hFEDCBA;
    clear_logs1();
    d0 = done1_cnt;
    pulse_start1(sc);
    repeat (300) tick();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_latch_rise(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_latch_a: latch ready rise seen=%0d expected 1", ok);
    end
    tick();
    start[1] = 1'b1;
    tick();
    n_checks++;
    if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_a: done=%b busy=%b expected 1 0", done[1], busy[1]);
    end
    start[1] = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (busy[1] !== 1'b0 || req1_q.size() != 49 || done1_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL b2b_no_restart: busy=%b %0d requests %0d dones expected 0 49 1", busy[1], req1_q.size(), done1_cnt - d0);
    end
    pulse_start1(sc);
    wait_latch_rise(ok);
    tick();
    start[1] = 1'b1;
    tick();
    n_checks++;
    if (!ok || done[1] !== 1'b1 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_b: ok=%0d done=%b busy=%b expected 1 1 0", ok, done[1], busy[1]);
    end
    tick();
    n_checks++;
    if (busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_held_start: busy=%b expected 1", busy[1]);
    end
    start[1] = 1'b0;
    wait_busy_low(1, 20000, ok);
    n_checks++;
    if (!ok || req1_q.size() != 147 || done1_cnt != d0 + 3) begin
      n_fail++;
      $display("FAIL b2b_totals: ok=%0d %0d requests %0d dones expected 1 147 3", ok, req1_q.size(), done1_cnt - d0);
    end
    mism = 0;
    foreach (req1_q[i]) if (req1_q[i] != exp_req(buf1[0], buf1[1], i % 49)) mism++;
    n_checks++;
    if (mism != 0 || multi_req != 0) begin
      n_fail++;
      $display("FAIL b2b_stream: %0d wrong requests, %0d overlapping, expected 0 0", mism, multi_req);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int sc;
    int l0;
    int mism;
    buf1[0] = 24'hA50F3C;
    buf1[1] = 24'h00FF81;
    clear_logs1();
    l0 = lat1_cnt;
    pulse_start1(sc);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      tick();
      if (req1_q.size() >= 11) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_reach_bit10: got %0d requests expected 11", req1_q.size());
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy[1] !== 1'b0 || done[1] !== 1'b0 || err[1] !== 1'b0 || pix_rd[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_status: busy=%b done=%b err=%b pix_rd=%b expected 0", busy[1], done[1], err[1], pix_rd[1]);
    end
    n_checks++;
    if (addr1 !== 3'd0 || {w0[1], w1[1], lat[1]} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_out: addr=%0d req=%b%b%b expected 0 000", addr1, w0[1], w1[1], lat[1]);
    end
    reset = 1'b0;
    repeat (100) tick();
    n_checks++;
    if (lat1_cnt != l0 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_latch: %0d latches busy=%b expected 0 0", lat1_cnt - l0, busy[1]);
    end
    clear_logs1();
    pulse_start1(sc);
    wait_busy_low(1, 20000, ok);
    mism = 0;
    foreach (req1_q[i]) if (req1_q[i] != exp_req(buf1[0], buf1[1], i)) mism++;
    n_checks++;
    if (!ok || req1_q.size() != 49 || mism != 0) begin
      n_fail++;
      $display("FAIL mid_refresh: ok=%0d %0d requests %0d wrong expected 1 49 0", ok, req1_q.size(), mism);
    end
    n_checks++;
    if (addr1_q.size() != 2 || addr1_q[0] != 0 || addr1_q[1] != 1) begin
      n_fail++;
      $display("FAIL mid_addr: %0d reads first=%0d expected 2 reads 0,1", addr1_q.size(), addr1_q[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 2'b00;
    buf0  = 24'h000000;
    for (int i = 0; i < 8; i++) buf1[i] = 24'h000000;
    test_reset();
    test_single_pixel();
    test_two_pixels();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation still running at cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
